// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// instruction classes, opcode/funct constants and load/store select codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LUI,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_LOAD,
        CLS_STORE,
        CLS_FRHT,
        CLS_ILLEGAL
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h05;
    localparam logic [5:0] OP_SLTI  = 6'h06;
    localparam logic [5:0] OP_SLTIU = 6'h07;
    localparam logic [5:0] OP_BEQ   = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_BNE   = 6'h10;
    localparam logic [5:0] OP_J     = 6'h11;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_FRHT  = 6'h3F;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [1:0] LOAD_SEL_NONE = 2'b00;
    localparam logic [1:0] LOAD_SEL_BYTE = 2'b01;
    localparam logic [1:0] LOAD_SEL_HALF = 2'b10;
    localparam logic [1:0] LOAD_SEL_LUI  = 2'b11;

    localparam logic [1:0] STORE_SEL_NONE = 2'b00;
    localparam logic [1:0] STORE_SEL_HALF = 2'b01;
    localparam logic [1:0] STORE_SEL_WORD = 2'b10;

    typedef struct packed {
        logic       zero_or_sign;
        logic       lui_or_other;
        logic       alusrc;
        logic       write_select;
        logic [1:0] load_select;
        logic [1:0] store_signal;
    } decode_ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Memory request/handshake bundle between the control unit and the memory.
interface multicycle_control_unit_if;
    logic mem_req;
    logic memRead;
    logic memWrite;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output memRead, output memWrite, output iord, input mem_ready);
    modport slave  (input mem_req, input memRead, input memWrite, input iord, output mem_ready);
endinterface

// File: rtl/opcode_decoder.sv
// Purely combinational instruction classification and decode-control generation.
module opcode_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int FRHT_EN = 1
) (
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output decode_ctrl_t ctrl
);

    always_comb begin
        cls  = CLS_ILLEGAL;
        ctrl = '0;

        case (opcode)
            OP_RTYPE:                          cls = (funct == FUNCT_JR) ? CLS_JUMP : CLS_ALU;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: cls = CLS_ALU;
            OP_BEQ, OP_BNE:                    cls = CLS_BRANCH;
            OP_J:                              cls = CLS_JUMP;
            OP_LUI:                            cls = CLS_LUI;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: cls = CLS_LOAD;
            OP_SB, OP_SH, OP_SW:               cls = CLS_STORE;
            OP_FRHT:                           cls = (FRHT_EN != 0) ? CLS_FRHT : CLS_ILLEGAL;
            default:                           cls = CLS_ILLEGAL;
        endcase

        ctrl.zero_or_sign = (opcode == OP_LB)   || (opcode == OP_LH)   ||
                            (opcode == OP_ADDI) || (opcode == OP_ADDIU) ||
                            (opcode == OP_SLTI) || (opcode == OP_SLTIU);
        ctrl.lui_or_other = (cls == CLS_LUI);
        ctrl.alusrc       = (opcode != OP_RTYPE);
        ctrl.write_select = (cls == CLS_LOAD) || (cls == CLS_STORE);

        case (opcode)
            OP_LB:   ctrl.load_select = LOAD_SEL_BYTE;
            OP_LH:   ctrl.load_select = LOAD_SEL_HALF;
            OP_LUI:  ctrl.load_select = LOAD_SEL_LUI;
            default: ctrl.load_select = LOAD_SEL_NONE;
        endcase

        case (opcode)
            OP_SH:   ctrl.store_signal = STORE_SEL_HALF;
            OP_SW:   ctrl.store_signal = STORE_SEL_WORD;
            default: ctrl.store_signal = STORE_SEL_NONE;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FSM sequencing FETCH/DECODE/EXEC/MEM/WB with memory wait timeout,
// multi-cycle frht execution and a reset-only ERR halt state.
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int FRHT_CYCLES = 4,
    parameter int FRHT_EN     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [5:0]                 opcode,
    input  logic [5:0]                 funct,
    multicycle_control_unit_if.master  mem,
    output logic                       ir_write,
    output logic                       pc_inc,
    output logic                       signal_regWrite,
    output logic                       jump_signal,
    output logic                       branch_signal,
    output logic                       frht_signal,
    output logic                       zero_or_sign,
    output logic                       lui_or_other,
    output logic                       alusrc,
    output logic                       write_select,
    output logic [1:0]                 load_select,
    output logic [1:0]                 store_signal,
    output logic [2:0]                 state_o,
    output logic                       illegal_op,
    output logic                       timeout_err,
    output logic                       halted
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [7:0] FRHT_LOAD = 8'(FRHT_CYCLES - 1);

    state_t             state_reg, state_next;
    logic               run_reg;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [7:0]         frht_cnt_reg, frht_cnt_next;
    instr_class_t       cls_reg;
    decode_ctrl_t       ctrl_reg;
    logic               illegal_reg, illegal_next;
    logic               timeout_reg, timeout_next;

    instr_class_t       dec_cls;
    decode_ctrl_t       dec_ctrl;

    opcode_decoder #(.FRHT_EN(FRHT_EN)) u_decoder (
        .opcode (opcode),
        .funct  (funct),
        .cls    (dec_cls),
        .ctrl   (dec_ctrl)
    );

    // run_reg holds off the first request until the cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= FETCH;
            run_reg      <= 1'b0;
            wait_cnt_reg <= '0;
            frht_cnt_reg <= '0;
            cls_reg      <= CLS_ALU;
            ctrl_reg     <= '0;
            illegal_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            run_reg      <= 1'b1;
            wait_cnt_reg <= wait_cnt_next;
            frht_cnt_reg <= frht_cnt_next;
            illegal_reg  <= illegal_next;
            timeout_reg  <= timeout_next;
            if (state_reg == DECODE) begin
                cls_reg  <= dec_cls;
                ctrl_reg <= dec_ctrl;
            end
        end
    end

    // Wait counter defaults to zero everywhere it is not actively counting,
    // so every entry into FETCH or MEM starts from a cleared count.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        frht_cnt_next = frht_cnt_reg;
        illegal_next  = illegal_reg;
        timeout_next  = timeout_reg;

        case (state_reg)
            FETCH: begin
                if (run_reg) begin
                    if (mem.mem_ready) begin
                        state_next = DECODE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        state_next   = ERR;
                        timeout_next = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                    end
                end
            end
            DECODE: begin
                if (dec_cls == CLS_ILLEGAL) begin
                    state_next   = ERR;
                    illegal_next = 1'b1;
                end else begin
                    state_next    = EXEC;
                    frht_cnt_next = FRHT_LOAD;
                end
            end
            EXEC: begin
                case (cls_reg)
                    CLS_BRANCH, CLS_JUMP: state_next = FETCH;
                    CLS_LOAD, CLS_STORE:  state_next = MEM;
                    CLS_FRHT: begin
                        if (frht_cnt_reg == 8'd0) state_next = WB;
                        else                      frht_cnt_next = frht_cnt_reg - 8'd1;
                    end
                    default:              state_next = WB;
                endcase
            end
            MEM: begin
                if (mem.mem_ready) begin
                    state_next = (cls_reg == CLS_LOAD) ? WB : FETCH;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    state_next   = ERR;
                    timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            WB:      state_next = FETCH;
            ERR:     state_next = ERR;
            default: state_next = ERR;
        endcase
    end

    always_comb begin
        mem.mem_req     = run_reg && ((state_reg == FETCH) || (state_reg == MEM));
        mem.memRead     = run_reg && ((state_reg == FETCH) ||
                                      ((state_reg == MEM) && (cls_reg == CLS_LOAD)));
        mem.memWrite    = (state_reg == MEM) && (cls_reg == CLS_STORE);
        mem.iord        = (state_reg == MEM);
        ir_write        = (state_reg == DECODE);
        pc_inc          = (state_reg == DECODE);
        signal_regWrite = (state_reg == WB);
        jump_signal     = (state_reg == EXEC) && (cls_reg == CLS_JUMP);
        branch_signal   = (state_reg == EXEC) && (cls_reg == CLS_BRANCH);
        frht_signal     = (state_reg == EXEC) && (cls_reg == CLS_FRHT);
        halted          = (state_reg == ERR);
        state_o         = state_reg;
        illegal_op      = illegal_reg;
        timeout_err     = timeout_reg;
        zero_or_sign    = ctrl_reg.zero_or_sign;
        lui_or_other    = ctrl_reg.lui_or_other;
        alusrc          = ctrl_reg.alusrc;
        write_select    = ctrl_reg.write_select;
        load_select     = ctrl_reg.load_select;
        store_signal    = ctrl_reg.store_signal;
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised instruction stream checked cycle-by-cycle against a per-instruction
// state-sequence model; includes timeout, mid-MEM reset and frht-disabled cases.
module tb_multicycle_control_unit;
    import mc_ctrl_pkg::*;

    localparam int TIMEOUT_N = 16;
    localparam int FRHT_N    = 4;
    localparam int K_ALU = 0, K_LUI = 1, K_BR = 2, K_JMP = 3, K_LD = 4, K_ST = 5, K_FRHT = 6, K_ILL = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       ir_write, pc_inc, signal_regWrite, jump_signal, branch_signal, frht_signal;
    logic       zero_or_sign, lui_or_other, alusrc, write_select;
    logic [1:0] load_select, store_signal;
    logic [2:0] state_o;
    logic       illegal_op, timeout_err, halted;

    multicycle_control_unit_if bus ();

    multicycle_control_unit #(.MEM_TIMEOUT(TIMEOUT_N), .FRHT_CYCLES(FRHT_N), .FRHT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem(bus),
        .ir_write(ir_write), .pc_inc(pc_inc), .signal_regWrite(signal_regWrite),
        .jump_signal(jump_signal), .branch_signal(branch_signal), .frht_signal(frht_signal),
        .zero_or_sign(zero_or_sign), .lui_or_other(lui_or_other), .alusrc(alusrc),
        .write_select(write_select), .load_select(load_select), .store_signal(store_signal),
        .state_o(state_o), .illegal_op(illegal_op), .timeout_err(timeout_err), .halted(halted)
    );

    // Second instance with frht disabled; memory answers immediately.
    logic [5:0] nf_opcode = 6'h3F;
    logic [5:0] nf_funct  = 6'h00;
    logic       nf_irw, nf_pci, nf_rw, nf_jmp, nf_br, nf_fr, nf_zos, nf_lui, nf_asrc, nf_wsel;
    logic [1:0] nf_ls, nf_ss;
    logic [2:0] nf_state;
    logic       nf_ill, nf_to, nf_hlt;
    multicycle_control_unit_if nf_bus ();
    assign nf_bus.mem_ready = nf_bus.mem_req;

    multicycle_control_unit #(.MEM_TIMEOUT(TIMEOUT_N), .FRHT_CYCLES(FRHT_N), .FRHT_EN(0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .opcode(nf_opcode), .funct(nf_funct), .mem(nf_bus),
        .ir_write(nf_irw), .pc_inc(nf_pci), .signal_regWrite(nf_rw),
        .jump_signal(nf_jmp), .branch_signal(nf_br), .frht_signal(nf_fr),
        .zero_or_sign(nf_zos), .lui_or_other(nf_lui), .alusrc(nf_asrc),
        .write_select(nf_wsel), .load_select(nf_ls), .store_signal(nf_ss),
        .state_o(nf_state), .illegal_op(nf_ill), .timeout_err(nf_to), .halted(nf_hlt)
    );

    logic [15:0] obs;
    logic [7:0]  obs_dec;
    assign obs = {state_o, bus.mem_req, bus.memRead, bus.memWrite, bus.iord, ir_write, pc_inc,
                  signal_regWrite, jump_signal, branch_signal, frht_signal,
                  illegal_op, timeout_err, halted};
    assign obs_dec = {zero_or_sign, lui_or_other, alusrc, write_select, load_select, store_signal};

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (fn == 6'h08) ? K_JMP : K_ALU;
        if (op inside {6'h04, 6'h05, 6'h06, 6'h07}) return K_ALU;
        if (op == 6'h0F) return K_LUI;
        if (op inside {6'h0E, 6'h10}) return K_BR;
        if (op == 6'h11) return K_JMP;
        if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return K_LD;
        if (op inside {6'h28, 6'h29, 6'h2B}) return K_ST;
        if (op == 6'h3F) return K_FRHT;
        return K_ILL;
    endfunction

    function automatic logic [7:0] exp_dec(input logic [5:0] op);
        logic       zos, lui, asrc, wsel;
        logic [1:0] ls, ss;
        zos  = op inside {6'h20, 6'h21, 6'h04, 6'h05, 6'h06, 6'h07};
        lui  = (op == 6'h0F);
        asrc = (op != 6'h00);
        wsel = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
        ls   = (op == 6'h20) ? 2'b01 : (op == 6'h21) ? 2'b10 : (op == 6'h0F) ? 2'b11 : 2'b00;
        ss   = (op == 6'h29) ? 2'b01 : (op == 6'h2B) ? 2'b10 : 2'b00;
        return {zos, lui, asrc, wsel, ls, ss};
    endfunction

    // Expected outputs for one cycle spent in state s by an instruction of kind k.
    function automatic logic [15:0] bits(input state_t s, input int k, input logic ill, input logic to);
        logic mreq = 0, mrd = 0, mwr = 0, iord = 0, irw = 0, pci = 0;
        logic rw = 0, jmp = 0, br = 0, fr = 0, hlt = 0;
        case (s)
            FETCH:  begin mreq = 1; mrd = 1; end
            DECODE: begin irw = 1; pci = 1; end
            EXEC:   begin jmp = (k == K_JMP); br = (k == K_BR); fr = (k == K_FRHT); end
            MEM:    begin mreq = 1; iord = 1; mrd = (k == K_LD); mwr = (k == K_ST); end
            WB:     rw = 1;
            default: hlt = 1;
        endcase
        return {3'(s), mreq, mrd, mwr, iord, irw, pci, rw, jmp, br, fr, ill, to, hlt};
    endfunction

    function automatic logic [15:0] idle_bits();
        return {3'(FETCH), 13'b0};
    endfunction

    task automatic step(input string tag, input logic [15:0] exp, input logic rdy);
        check_val(tag, obs, exp);
        bus.mem_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic noise();
        return 1'($urandom_range(0, 1));
    endfunction

    // lat_m == 0 means memory never answers in MEM.
    task automatic run_instr(input int idx, input logic [5:0] op, input logic [5:0] fn,
                             input int lat_f, input int lat_m);
        int k;
        int ncyc;
        k = kind_of(op, fn);
        ncyc = 0;
        opcode = op;
        funct  = fn;
        for (int c = 1; c <= lat_f; c++) begin
            step($sformatf("i%0d_fetch%0d", idx, c), bits(FETCH, k, 0, 0), c == lat_f);
            ncyc++;
        end
        step($sformatf("i%0d_decode", idx), bits(DECODE, k, 0, 0), noise());
        ncyc++;
        for (int c = 1; c <= ((k == K_FRHT) ? FRHT_N : 1); c++) begin
            if (c == 1) check_val($sformatf("i%0d_decctl", idx), obs_dec, exp_dec(op));
            step($sformatf("i%0d_exec%0d", idx, c), bits(EXEC, k, 0, 0), noise());
            ncyc++;
        end
        if (k == K_LD || k == K_ST) begin
            if (lat_m == 0) begin
                for (int c = 1; c <= TIMEOUT_N; c++) begin
                    step($sformatf("i%0d_memwait%0d", idx, c), bits(MEM, k, 0, 0), 1'b0);
                    ncyc++;
                end
                for (int c = 1; c <= 3; c++)
                    step($sformatf("i%0d_err%0d", idx, c), bits(ERR, k, 0, 1), noise());
                $display("instr %0d op=%02h timeout after %0d cycles", idx, op, ncyc);
                return;
            end
            for (int c = 1; c <= lat_m; c++) begin
                step($sformatf("i%0d_mem%0d", idx, c), bits(MEM, k, 0, 0), c == lat_m);
                ncyc++;
            end
        end
        if (k != K_BR && k != K_JMP && k != K_ST) begin
            step($sformatf("i%0d_wb", idx), bits(WB, k, 0, 0), noise());
            ncyc++;
        end
        $display("instr %0d op=%02h funct=%02h lat_f=%0d lat_m=%0d cycles=%0d", idx, op, fn, lat_f, lat_m, ncyc);
    endtask

    logic [5:0] legal_ops [18] = '{6'h00, 6'h04, 6'h05, 6'h06, 6'h07, 6'h0E, 6'h0F, 6'h10, 6'h11,
                                   6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F};

    task automatic run_random(input int idx);
        logic [5:0] op, fn;
        int lm;
        op = legal_ops[$urandom_range(0, 17)];
        fn = 6'($urandom_range(0, 63));
        if (op == 6'h00 && $urandom_range(0, 3) == 0) fn = 6'h08;
        lm = ($urandom_range(0, 9) == 0) ? TIMEOUT_N : int'($urandom_range(1, 4));
        run_instr(idx, op, fn, int'($urandom_range(1, 4)), lm);
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = 6'h00;
        funct = 6'h00;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_val("reset_outputs", obs, idle_bits());
        check_val("reset_decctl", obs_dec, 8'h00);
        check_val("reset_nf_state", {nf_state, nf_bus.mem_req, nf_ill, nf_hlt}, 6'b0);
        rst_n = 1'b1;
        step("post_reset_idle", idle_bits(), 1'b0);

        run_instr(0, 6'h04, 6'h00, 3, 0);
        run_instr(1, 6'h23, 6'h00, 3, 3);
        run_instr(2, 6'h2B, 6'h00, 2, 2);
        run_instr(3, 6'h3F, 6'h00, 1, 0);
        run_instr(4, 6'h11, 6'h00, 1, 0);
        run_instr(5, 6'h00, 6'h08, 2, 0);
        run_instr(6, 6'h0E, 6'h00, 1, 0);
        run_instr(7, 6'h0F, 6'h00, 1, 0);
        run_instr(8, 6'h23, 6'h00, 1, TIMEOUT_N);
        run_instr(9, 6'h00, 6'h20, 4, 0);
        for (int i = 10; i < 50; i++) run_random(i);

        // Reset asserted while a load waits in MEM.
        opcode = 6'h23;
        funct  = 6'h00;
        step("rst_fetch", bits(FETCH, K_LD, 0, 0), 1'b1);
        step("rst_decode", bits(DECODE, K_LD, 0, 0), 1'b0);
        step("rst_exec", bits(EXEC, K_LD, 0, 0), 1'b0);
        step("rst_mem1", bits(MEM, K_LD, 0, 0), 1'b0);
        check_val("pre_rst_memreq", bus.mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_memreq_drop", bus.mem_req, 1'b0);
        check_val("rst_outputs", obs, idle_bits());
        @(negedge clk);
        rst_n = 1'b1;
        check_val("rst_decctl_clear", obs_dec, 8'h00);
        step("rst_release_idle", idle_bits(), 1'b1);
        for (int i = 50; i < 58; i++) run_random(i);

        run_instr(58, 6'h23, 6'h00, 2, 0);

        check_val("nf_state_err", nf_state, 3'(ERR));
        check_val("nf_illegal", nf_ill, 1'b1);
        check_val("nf_halted", nf_hlt, 1'b1);
        check_val("nf_timeout", nf_to, 1'b0);
        check_val("nf_memreq", nf_bus.mem_req, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
